// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} div_state_e;

  // Quotient reported for a zero divisor: all ones at width w (w up to 64).
  function automatic logic [63:0] div0_quotient(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/div_addsub.sv
// (W)-bit adder/subtractor; subtraction is a + ~b + 1 with the +1 as carry-in.
module div_addsub #(
  parameter int W = 17
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] y_o
);

  logic [W-1:0] b_eff;

  always_comb begin
    b_eff = sub_i ? ~b_i : b_i;
    y_o   = a_i + b_eff + W'(sub_i);
  end

endmodule

// File: rtl/seq_divider.sv
// Radix-2 non-restoring sequential divider, signed/unsigned, one quotient bit
// per cycle with a one-cycle sign/remainder fixup and a valid/ready result.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] DIV0_Q = WIDTH'(div0_quotient(WIDTH));

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   pr_q, pr_d;     // signed partial remainder
  logic [WIDTH-1:0] qr_q, qr_d;     // |N| shifting out, quotient shifting in
  logic [WIDTH-1:0] dabs_q, dabs_d;
  logic             nneg_q, nneg_d;
  logic             qneg_q, qneg_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic             op_signed, n_neg, d_neg, d_zero;
  logic [WIDTH-1:0] n_abs, d_abs, rem_mag;
  logic [WIDTH:0]   as_a, as_b, as_y;
  logic             as_sub;

  always_comb begin
    op_signed = SIGNED_EN && is_signed;
    n_neg     = op_signed && dividend[WIDTH-1];
    d_neg     = op_signed && divisor[WIDTH-1];
    d_zero    = (divisor == '0);
    n_abs     = n_neg ? (~dividend + WIDTH'(1)) : dividend;
    d_abs     = d_neg ? (~divisor + WIDTH'(1)) : divisor;
  end

  // Shared unit: iteration step in CALC, final remainder correction in FIXUP.
  always_comb begin
    as_a   = (state_q == FIXUP) ? pr_q : {pr_q[WIDTH-1:0], qr_q[WIDTH-1]};
    as_b   = {1'b0, dabs_q};
    as_sub = (state_q == CALC) && !pr_q[WIDTH];
  end

  div_addsub #(.W(WIDTH + 1)) u_addsub (
    .a_i   (as_a),
    .b_i   (as_b),
    .sub_i (as_sub),
    .y_o   (as_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pr_q    <= '0;
      qr_q    <= '0;
      dabs_q  <= '0;
      nneg_q  <= 1'b0;
      qneg_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      qr_q    <= qr_d;
      dabs_q  <= dabs_d;
      nneg_q  <= nneg_d;
      qneg_q  <= qneg_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = d_zero ? DONE : CALC;
      CALC:    if (cnt_q == CNT_W'(1)) state_d = FIXUP;
      FIXUP:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    pr_d    = pr_q;
    qr_d    = qr_q;
    dabs_d  = dabs_q;
    nneg_d  = nneg_q;
    qneg_d  = qneg_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    rem_mag = pr_q[WIDTH] ? as_y[WIDTH-1:0] : pr_q[WIDTH-1:0];
    case (state_q)
      IDLE: if (in_valid) begin
        cnt_d  = CNT_W'(WIDTH);
        pr_d   = '0;
        qr_d   = n_abs;
        dabs_d = d_abs;
        nneg_d = n_neg;
        qneg_d = n_neg ^ d_neg;
        if (d_zero) begin
          quot_d = DIV0_Q;
          rem_d  = dividend;
          dbz_d  = 1'b1;
        end
      end
      CALC: begin
        pr_d  = as_y;
        qr_d  = {qr_q[WIDTH-2:0], ~as_y[WIDTH]};
        cnt_d = cnt_q - CNT_W'(1);
      end
      FIXUP: begin
        quot_d = qneg_q ? (~qr_q + WIDTH'(1)) : qr_q;
        rem_d  = nneg_q ? (~rem_mag + WIDTH'(1)) : rem_mag;
        dbz_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == IDLE);
    out_valid   = (state_q == DONE);
    quotient    = quot_q;
    remainder   = rem_q;
    div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider at WIDTH=16.
module tb_seq_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         is_signed;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .is_signed   (is_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Issue one op from a negedge; returns at the negedge where out_valid is
  // first seen, lat = cycles from the accept edge (capped at 100).
  task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] d,
                        input logic s, output int lat);
    @(negedge clk);
    dividend  = n;
    divisor   = d;
    is_signed = s;
    in_valid  = 1'b1;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 100);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== '0 ||
        remainder !== '0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset: ov=%b ir=%b q=%h r=%h z=%b, want ov=0 ir=1 q=0 r=0 z=0",
               out_valid, in_ready, quotient, remainder, div_by_zero);
    end
  endtask

  // Directed vectors: n, d, signed, q, r, dbz, latency.
  task automatic test_vectors();
    logic [W-1:0] vn [8] = '{16'd13205, 16'hFFF9, 16'hFFF9, 16'h8000, 16'h0007, 16'hFFFF, 16'hFFFF, 16'h0000};
    logic [W-1:0] vd [8] = '{16'd486,   16'h0002, 16'h0002, 16'hFFFF, 16'hFFFE, 16'hFFFF, 16'h0001, 16'h0005};
    logic         vs [8] = '{1'b0,      1'b1,     1'b0,     1'b1,     1'b1,     1'b0,     1'b0,     1'b1};
    logic [W-1:0] eq [8] = '{16'd27,    16'hFFFD, 16'h7FFC, 16'h8000, 16'hFFFD, 16'h0001, 16'hFFFF, 16'h0000};
    logic [W-1:0] er [8] = '{16'd83,    16'hFFFF, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000};
    int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(vn[i], vd[i], vs[i], lat);
      checks++;
      if (quotient !== eq[i] || remainder !== er[i] || div_by_zero !== 1'b0 || lat != W + 2) begin
        errors++;
        $display("FAIL vec%0d %h/%h s=%b: got q=%h r=%h z=%b lat=%0d, want q=%h r=%h z=0 lat=%0d",
                 i, vn[i], vd[i], vs[i], quotient, remainder, div_by_zero, lat, eq[i], er[i], W + 2);
      end
      consume();
    end
  endtask

  task automatic test_div_zero();
    int lat;
    for (int s = 0; s < 2; s++) begin
      run_op(16'd100, 16'd0, s[0], lat);
      checks++;
      if (quotient !== 16'hFFFF || remainder !== 16'd100 || div_by_zero !== 1'b1 || lat != 1) begin
        errors++;
        $display("FAIL div0 s=%0d: got q=%h r=%0d z=%b lat=%0d, want q=ffff r=100 z=1 lat=1",
                 s, quotient, remainder, div_by_zero, lat);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(16'd13205, 16'd486, 1'b0, lat);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      dividend = 16'h1234;
      divisor  = 16'd3;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 16'd27 ||
          remainder !== 16'd83 || div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d: ov=%b ir=%b q=%0d r=%0d z=%b, want ov=1 ir=0 q=27 r=83 z=0",
                 c, out_valid, in_ready, quotient, remainder, div_by_zero);
      end
    end
    consume();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL release: ir=%b ov=%b, want ir=1 ov=0", in_ready, out_valid);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    dividend  = 16'd1000;
    divisor   = 16'd7;
    is_signed = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: ov=%b ir=%b, want ov=0 ir=1", out_valid, in_ready);
    end
    run_op(16'd1000, 16'd7, 1'b0, lat);
    checks++;
    if (quotient !== 16'd142 || remainder !== 16'd6 || div_by_zero !== 1'b0 || lat != W + 2) begin
      errors++;
      $display("FAIL after_reset: q=%0d r=%0d z=%b lat=%0d, want q=142 r=6 z=0 lat=%0d",
               quotient, remainder, div_by_zero, lat, W + 2);
    end
    consume();
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    is_signed = 1'b0;
    test_reset();
    test_vectors();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; legal range 4..64.
REQ-002 Parameter SIGNED_EN, default 1; when 0, is_signed is ignored and all operations are unsigned.
REQ-003 clk  input  1  single rising-edge clock; one clock domain.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operands and mode valid this cycle.
REQ-006 in_ready  output  1  divider idle and able to accept operands.
REQ-007 dividend  input  WIDTH  numerator N.
REQ-008 divisor  input  WIDTH  denominator D.
REQ-009 is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-010 out_valid  output  1  result valid; held until consumed.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 quotient  output  WIDTH  Q = N/D, truncated toward zero.
REQ-013 remainder  output  WIDTH  R = N - Q*D; R carries the sign of N.
REQ-014 div_by_zero  output  1  the result came from D == 0.

Function
REQ-015 FSM states: IDLE, CALC, FIXUP, DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 Accept when in_valid & in_ready: register operands, mode and magnitudes |N|, |D|; then go to CALC, or to DONE if D == 0.
REQ-017 CALC: non-restoring radix-2; one quotient bit per cycle, MSB first; exactly WIDTH cycles, tracked by a down-counter of $clog2(WIDTH)+1 bits.
REQ-018 Each CALC cycle: shift the {partial remainder, quotient} pair left by 1. If the partial remainder is >= 0, subtract |D|; otherwise add |D|. The new quotient bit is the inverse of the result sign.
REQ-019 The partial remainder is WIDTH+1 bits wide; no intermediate overflow is permitted.
REQ-020 FIXUP, 1 cycle: if the partial remainder is negative, add |D|. Negate Q when the signs of N and D differ. Negate R when N < 0. Then go to DONE.
REQ-021 Latency: out_valid rises exactly WIDTH+2 cycles after the accept cycle; D == 0 results are valid 1 cycle after accept.
REQ-022 D == 0: quotient = all ones, remainder = dividend, div_by_zero = 1; applies in both modes.
REQ-023 Signed overflow (N = most-negative value, D = -1): quotient = most-negative value, remainder = 0, div_by_zero = 0.
REQ-024 DONE: out_valid = 1. quotient, remainder and div_by_zero SHALL stay stable while out_ready = 0.
REQ-025 out_valid & out_ready in DONE: go to IDLE next cycle. No new operands are accepted in the handshake cycle.
REQ-026 in_valid while not in IDLE is ignored; the operand inputs are don't-care.
REQ-027 Outputs are registered; no combinational path from in_* to out_*.

Reset
REQ-028 When reset = 1 at a clock edge: state = IDLE, out_valid = 0, in_ready = 1, quotient = 0, remainder = 0, div_by_zero = 0, counter = 0.
REQ-029 Reset mid-operation (CALC, FIXUP or DONE) SHALL abort the operation with no result emitted; reset takes priority over every handshake in the same cycle.

Structure
REQ-030 Package div_pkg holds the state enum typedef (IDLE, CALC, FIXUP, DONE) and the div-by-zero quotient constant generator.
REQ-031 One sub-module, div_addsub: a (WIDTH+1)-bit add/subtract unit with a sub select; subtraction is done as ~B + 1 via carry-in.
REQ-032 The FSM, counter and shift registers are in seq_divider; one always_ff block clocked on clk, with synchronous reset.

Verification
REQ-033 WIDTH=16, unsigned 13205 / 486 -> Q=27, R=83, div_by_zero=0; out_valid 18 cycles after accept.
REQ-034 Signed -7 / 2 (0xFFF9 / 0x0002) -> Q=0xFFFD (-3), R=0xFFFF (-1); unsigned 0xFFF9 / 2 -> Q=0x7FFC, R=1.
REQ-035 100 / 0 (either mode) -> Q=0xFFFF, R=100, div_by_zero=1; out_valid 1 cycle after accept.
REQ-036 Signed 0x8000 / 0xFFFF -> Q=0x8000, R=0, div_by_zero=0.
REQ-037 Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs unchanged and in_ready=0; raise out_ready -> in_ready=1 the next cycle.
REQ-038 Assert reset in CALC cycle 5 -> next cycle out_valid=0, in_ready=1; the following op 1000 / 7 -> Q=142, R=6.
